lcd_sequencer: RTL and testbench

Command/character sequencer that drives the single-byte LCD write controller on the PS/2 keyboard-to-LCD path. After reset it waits the HD44780 power-up time, issues the fixed initialization command list, then accepts ASCII characters from the keyboard decoder over a valid/ready handshake. It tracks the cursor on a 2x16 display, inserts DDRAM address commands at line ends, and services clear-screen requests. Every byte goes through the write controller's start/done handshake followed by a command-specific settle delay.

---
 rtl/lcd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_lcd_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_sequencer.sv
// HD44780 byte sequencer: power-up wait, init command list, then keyboard
// characters with cursor tracking, line-end address commands and clears.
`timescale 1ns/1ps
module lcd_sequencer #(
  parameter int POWERUP_WAIT = 750000,
  parameter int CMD_WAIT     = 2000,
  parameter int CLEAR_WAIT   = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       clear_req,
  input  logic       lcd_done,
  output logic       lcd_start,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       init_done,
  output logic       busy,
  output logic       cursor_row,
  output logic [3:0] cursor_col
);

  localparam logic [19:0] PWR_CYC = 20'(POWERUP_WAIT);
  localparam logic [19:0] CMD_CYC = 20'(CMD_WAIT);
  localparam logic [19:0] CLR_CYC = 20'(CLEAR_WAIT);

  typedef enum logic [2:0] {PWRUP, ISSUE, WAIT_LO, WAIT_HI, SETTLE, IDLE} state_t;

  state_t      state_reg;
  state_t      launch_state;
  logic [19:0] cnt_reg;
  logic [1:0]  init_idx_reg;
  logic        clear_pend_reg;
  logic        ready_reg;
  logic        is_clear;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // When the controller is already idle the start pulse goes out on the same
  // edge the byte is loaded, so a handshake at N yields lcd_start at N+1.
  assign launch_state = lcd_done ? WAIT_LO : ISSUE;
  assign is_clear     = (lcd_data == 8'h01) && !lcd_rs;
  // A clear arriving this cycle blocks the character so the clear goes first.
  assign char_ready   = ready_reg && !clear_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= PWRUP;
      cnt_reg        <= '0;
      init_idx_reg   <= '0;
      clear_pend_reg <= 1'b0;
      ready_reg      <= 1'b0;
      lcd_start      <= 1'b0;
      lcd_data       <= 8'h00;
      lcd_rs         <= 1'b0;
      init_done      <= 1'b0;
      busy           <= 1'b1;
      cursor_row     <= 1'b0;
      cursor_col     <= 4'd0;
    end else begin
      lcd_start <= 1'b0;
      ready_reg <= 1'b0;
      busy      <= 1'b1;
      if (clear_req) clear_pend_reg <= 1'b1;

      case (state_reg)
        PWRUP: begin
          if (cnt_reg >= PWR_CYC) begin
            init_idx_reg <= 2'd0;
            lcd_data     <= init_byte(2'd0);
            lcd_rs       <= 1'b0;
            lcd_start    <= lcd_done;
            state_reg    <= launch_state;
          end else begin
            cnt_reg <= cnt_reg + 20'd1;
          end
        end
        ISSUE: begin
          if (lcd_done) begin
            lcd_start <= 1'b1;
            state_reg <= WAIT_LO;
          end
        end
        WAIT_LO: if (!lcd_done) state_reg <= WAIT_HI;
        WAIT_HI: begin
          if (lcd_done) begin
            cnt_reg   <= is_clear ? CLR_CYC : CMD_CYC;
            state_reg <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_reg != 20'd0) begin
            cnt_reg <= cnt_reg - 20'd1;
          end else if (!init_done) begin
            if (init_idx_reg == 2'd3) begin
              // Init already cleared the display, so earlier clear requests are dropped.
              init_done      <= 1'b1;
              cursor_row     <= 1'b0;
              cursor_col     <= 4'd0;
              clear_pend_reg <= 1'b0;
              ready_reg      <= 1'b1;
              busy           <= 1'b0;
              state_reg      <= IDLE;
            end else begin
              init_idx_reg <= init_idx_reg + 2'd1;
              lcd_data     <= init_byte(init_idx_reg + 2'd1);
              lcd_rs       <= 1'b0;
              lcd_start    <= lcd_done;
              state_reg    <= launch_state;
            end
          end else if (lcd_rs && cursor_col == 4'd15) begin
            cursor_col <= 4'd0;
            cursor_row <= ~cursor_row;
            lcd_data   <= cursor_row ? 8'h80 : 8'hC0;
            lcd_rs     <= 1'b0;
            lcd_start  <= lcd_done;
            state_reg  <= launch_state;
          end else begin
            if (lcd_rs) begin
              cursor_col <= cursor_col + 4'd1;
            end else if (is_clear) begin
              cursor_row <= 1'b0;
              cursor_col <= 4'd0;
            end
            ready_reg <= !(clear_pend_reg || clear_req);
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        IDLE: begin
          if (clear_pend_reg) begin
            clear_pend_reg <= clear_req;
            lcd_data       <= 8'h01;
            lcd_rs         <= 1'b0;
            lcd_start      <= lcd_done;
            state_reg      <= launch_state;
          end else if (char_valid && char_ready) begin
            lcd_data  <= char_data;
            lcd_rs    <= 1'b1;
            lcd_start <= lcd_done;
            state_reg <= launch_state;
          end else begin
            ready_reg <= !clear_req;
            busy      <= 1'b0;
          end
        end
        default: state_reg <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer: write-controller model, byte-stream
// reference model with cursor tracking, and directed/random character traffic.
`timescale 1ns/1ps
module tb_lcd_sequencer;
  localparam int PW  = 10;
  localparam int CW  = 3;
  localparam int CLW = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       clear_req = 1'b0;
  logic       lcd_done = 1'b1;
  logic       char_ready, lcd_start, lcd_rs, init_done, busy, cursor_row;
  logic [7:0] lcd_data;
  logic [3:0] cursor_col;

  lcd_sequencer #(.POWERUP_WAIT(PW), .CMD_WAIT(CW), .CLEAR_WAIT(CLW)) dut (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .clear_req(clear_req), .lcd_done(lcd_done),
    .lcd_start(lcd_start), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .init_done(init_done), .busy(busy), .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int lat_min = 1;
  int lat_max = 3;
  logic [8:0] exp_q[$];
  logic [8:0] act_q[$];
  int exp_row = 0;
  int exp_col = 0;

  int         busy_cnt = 0;
  logic [8:0] held = '0;
  bit         have_prev = 0;
  bit         prev_start = 0;
  int         prev_cyc = 0;
  int         prev_settle = 0;
  int         rel_cyc = 0;
  int         last_start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: display byte stream and cursor from the command rules.
  task automatic model_init();
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001); exp_q.push_back(9'h006);
    exp_row = 0; exp_col = 0;
  endtask

  task automatic model_char(input logic [7:0] c);
    exp_q.push_back({1'b1, c});
    if (exp_col < 15) exp_col++;
    else begin
      exp_col = 0;
      exp_q.push_back(exp_row == 1 ? 9'h080 : 9'h0C0);
      exp_row = 1 - exp_row;
    end
  endtask

  task automatic model_clear();
    exp_q.push_back(9'h001);
    exp_row = 0; exp_col = 0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_cursor(input string tag);
    chk({tag, "_row"}, cursor_row, exp_row);
    chk({tag, "_col"}, cursor_col, exp_col);
  endtask

  // Write-controller model: done drops after a start, rises after a random latency.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        lcd_done = 1'b1; busy_cnt = 0; have_prev = 0; prev_start = 0; rel_cyc = cyc;
      end else begin
        if (lcd_start) begin
          chk("start_while_done", lcd_done, 1);
          chk("start_consecutive", prev_start, 0);
          if (have_prev) chk("settle_gap", (cyc - prev_cyc) >= prev_settle + 3, 1);
          else chk("powerup_gap", (cyc - rel_cyc) >= PW, 1);
          held = {lcd_rs, lcd_data};
          act_q.push_back(held);
          prev_settle = (lcd_data == 8'h01 && !lcd_rs) ? CLW : CW;
          prev_cyc = cyc; last_start_cyc = cyc; have_prev = 1;
          lcd_done = 1'b0;
          busy_cnt = $urandom_range(lat_max, lat_min);
        end else if (busy_cnt > 0) begin
          chk("data_hold", {lcd_rs, lcd_data}, held);
          busy_cnt--;
          if (busy_cnt == 0) lcd_done = 1'b1;
        end
        prev_start = lcd_start;
      end
    end
  end

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_init_done"}, init_done, 1);
    chk({tag, "_init_after_settle"}, cyc >= last_start_cyc + CW + 3, 1);
    chk({tag, "_ready"}, char_ready, 1);
  endtask

  // Waits for the handshake edge, then checks the start pulse one cycle later.
  task automatic accept_char(input logic [7:0] c);
    int n = 0;
    #1;
    while (char_ready !== 1'b1 && n < 4000) begin @(negedge clk); #1; n++; end
    chk("accept_ready", char_ready, 1);
    @(posedge clk); #1;
    chk("hs_start", lcd_start, 1);
    chk("hs_data", lcd_data, c);
    chk("hs_rs", lcd_rs, 1);
    chk("hs_ready_low", char_ready, 0);
  endtask

  task automatic release_wait();
    bit early = 0;
    int n = 0;
    @(negedge clk);
    char_valid = 1'b0;
    while (busy !== 1'b0 && n < 4000) begin
      if (char_ready !== 1'b0) early = 1;
      @(negedge clk); n++;
    end
    chk("ready_low_while_busy", early, 0);
    chk("return_idle", busy, 0);
  endtask

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    char_valid = 1'b1; char_data = c;
    model_char(c);
    accept_char(c);
    release_wait();
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] c2;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_start", lcd_start, 0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 1);
    chk("rst_row", cursor_row, 0);
    chk("rst_col", cursor_col, 0);
    reset = 1'b0;
    model_init();
    wait_init("init");
    check_writes("init");
    check_cursor("init");

    send_char(8'h41);
    check_cursor("single");
    check_writes("single");

    for (int i = 0; i < 31; i++) begin
      c = 8'($urandom_range(8'h7E, 8'h20));
      send_char(c);
      check_cursor($sformatf("wrap%0d", i));
    end
    check_writes("wrap");

    send_char(8'($urandom_range(8'h7E, 8'h20)));
    send_char(8'($urandom_range(8'h7E, 8'h20)));
    @(negedge clk);
    char_valid = 1'b1; char_data = 8'h42; clear_req = 1'b1;
    #1 chk("clr_prio_ready", char_ready, 0);
    @(negedge clk);
    clear_req = 1'b0;
    model_clear();
    model_char(8'h42);
    accept_char(8'h42);
    release_wait();
    check_cursor("clr_prio");
    check_writes("clr_prio");

    c = 8'($urandom_range(8'h7E, 8'h20));
    c2 = 8'($urandom_range(8'h7E, 8'h20));
    @(negedge clk);
    char_valid = 1'b1; char_data = c;
    model_char(c);
    accept_char(c);
    @(negedge clk);
    char_data = c2; clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    model_clear();
    model_char(c2);
    accept_char(c2);
    release_wait();
    check_cursor("clr_busy");
    check_writes("clr_busy");

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(5, 0) == 0) begin
        @(negedge clk); clear_req = 1'b1;
        @(negedge clk); clear_req = 1'b0;
        model_clear();
        @(negedge clk);
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        chk("mix_clear_idle", busy, 0);
      end else begin
        send_char(8'($urandom_range(8'h7E, 8'h20)));
      end
      check_cursor($sformatf("mix%0d", i));
    end
    check_writes("mix");

    lat_min = 4; lat_max = 4;
    c = 8'($urandom_range(8'h7E, 8'h20));
    @(negedge clk);
    char_valid = 1'b1; char_data = c;
    accept_char(c);
    @(posedge clk); #1;
    reset = 1'b1; char_valid = 1'b0;
    #1;
    chk("midrst_start", lcd_start, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_row", cursor_row, 0);
    chk("midrst_col", cursor_col, 0);
    chk("midrst_busy", busy, 1);
    repeat (2) @(negedge clk);
    act_q.delete();
    exp_q.delete();
    lat_min = 1; lat_max = 3;
    reset = 1'b0;
    model_init();
    wait_init("reinit");
    check_writes("reinit");
    check_cursor("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
